// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity encodings, FSM state
// encoding and the frame-length helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // ST_ prefix keeps state names clear of the PARITY module parameter.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } tx_state_t;

    function automatic int unsigned frame_len(input int unsigned cpb,
                                              input int unsigned data_bits,
                                              input int unsigned parity,
                                              input int unsigned stop_bits);
        return (1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits) * cpb;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter; tick marks the last clock of each bit.
// clear realigns the count so a new frame starts on a fresh bit boundary.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (data width, parity, stop bits) with a
// valid/ready input. Define UART_TX_BREAK_EN to add the tx_break line-break input.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 busy
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
        DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
        $error("uart_tx_cfg: illegal parameter combination");
    end

    // Handshake: a word is taken on every rising edge where tx_valid and
    // tx_ready are both high; tx_ready depends only on state and reset, never
    // on tx_valid, and an unaccepted word is simply held off by the producer.
    tx_state_t                state;
    logic [DATA_BITS-1:0]     shift_reg;
    logic [3:0]               bit_cnt;
    logic                     par_bit;
    logic                     tick;
    logic                     accept;

`ifdef UART_TX_BREAK_EN
    localparam int FRAME_LEN = int'(frame_len(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS));
    localparam int BW = $clog2(FRAME_LEN);
    logic [BW-1:0] brk_cnt;

    // A pending break blocks acceptance so the word stays with the producer.
    assign tx_ready = (state == ST_IDLE) && !reset && !tx_break;
`else
    assign tx_ready = (state == ST_IDLE) && !reset;
`endif

    assign accept = tx_valid && tx_ready;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(accept),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (tx_break) begin
                        state   <= ST_BREAK;
                        tx_out  <= 1'b0;
                        brk_cnt <= '0;
                    end else
`endif
                    if (accept) begin
                        state     <= ST_START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                        shift_reg <= tx_data;
                        par_bit   <= (^tx_data) ^ (PARITY == PAR_ODD);
                        bit_cnt   <= '0;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        state     <= ST_DATA;
                        tx_out    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= '0;
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                state  <= ST_PARITY;
                                tx_out <= par_bit;
                            end else begin
                                state  <= ST_STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            tx_out    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        state   <= ST_STOP;
                        tx_out  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                            tx_out <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

`ifdef UART_TX_BREAK_EN
                // Hold the line low for at least one frame time, longer while
                // tx_break stays asserted.
                ST_BREAK: begin
                    if (brk_cnt == BW'(FRAME_LEN - 1)) begin
                        if (!tx_break) begin
                            state  <= ST_IDLE;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        brk_cnt <= brk_cnt + BW'(1);
                    end
                end
`endif

                default: begin
                    state  <= ST_IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1, 8E1, 8O1, 7N2, all 4 clocks/bit)
// checked cycle by cycle on {tx_ready, busy, tx_out} against a frame model.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] txo;
    logic [3:0] bsy;
    logic [3:0] brk;
    logic [8:0] data;

    int n_vec = 0;
    int n_err = 0;

    localparam int CPB = 4;
    int cfg_db[4]  = '{8, 8, 8, 7};
    int cfg_par[4] = '{0, 2, 1, 0};
    int cfg_sb[4]  = '{1, 1, 1, 2};

    // Each entry: {tx_ready, busy, tx_out} expected for one clock.
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk[0]),
`endif
        .tx_valid(valid[0]), .tx_ready(ready[0]), .tx_data(data[7:0]),
        .tx_out(txo[0]), .busy(bsy[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk[1]),
`endif
        .tx_valid(valid[1]), .tx_ready(ready[1]), .tx_data(data[7:0]),
        .tx_out(txo[1]), .busy(bsy[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk[2]),
`endif
        .tx_valid(valid[2]), .tx_ready(ready[2]), .tx_data(data[7:0]),
        .tx_out(txo[2]), .busy(bsy[2]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(reset),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk[3]),
`endif
        .tx_valid(valid[3]), .tx_ready(ready[3]), .tx_data(data[6:0]),
        .tx_out(txo[3]), .busy(bsy[3]));

    function automatic int frame_clocks(input int sel);
        return (1 + cfg_db[sel] + ((cfg_par[sel] != 0) ? 1 : 0) + cfg_sb[sel]) * CPB;
    endfunction

    // Reference frame: start, data LSB first, optional parity, stop bits.
    task automatic push_frame(input int sel, input logic [8:0] w);
        int ones = 0;
        logic p;
        repeat (CPB) exp_q.push_back(3'b010);
        for (int b = 0; b < cfg_db[sel]; b++) begin
            ones += int'(w[b]);
            repeat (CPB) exp_q.push_back({2'b01, w[b]});
        end
        if (cfg_par[sel] != 0) begin
            p = (cfg_par[sel] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            repeat (CPB) exp_q.push_back({2'b01, p});
        end
        repeat (cfg_sb[sel] * CPB) exp_q.push_back(3'b011);
    endtask

    // Sends one word, or two words with tx_valid held high throughout, and
    // checks every following clock until the block is idle again.
    task automatic send_frames(input int sel, input int n, input logic [8:0] w0,
                               input logic [8:0] w1, input string name);
        int total;
        int len;
        logic [2:0] obs;
        logic [2:0] exp;
        len = frame_clocks(sel);
        @(negedge clk);
        n_vec++;
        if (ready[sel] !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before_send: got %b expected 1", name, ready[sel]);
        end
        valid[sel] = 1'b1;
        data = w0;
        push_frame(sel, w0);
        if (n == 2) begin
            exp_q.push_back(3'b101);
            push_frame(sel, w1);
        end
        exp_q.push_back(3'b101);
        total = exp_q.size();
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (i == 0) data = 9'($urandom_range(0, 511));
            obs = {ready[sel], bsy[sel], txo[sel]};
            exp = exp_q.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s clk %0d {ready,busy,tx_out}: got %b expected %b", name, i, obs, exp);
            end
            if (n == 2 && i == len) data = w1;
            if ((n == 1 && i == 0) || (n == 2 && i == len + 1)) valid[sel] = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        reset = 1'b1;
        valid = '0;
        brk   = '0;
        data  = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            obs = {ready[s], bsy[s], txo[s]};
            n_vec++;
            if (obs !== 3'b001) begin
                n_err++;
                $display("FAIL reset_state[%0d]: got %b expected 001", s, obs);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            obs = {ready[s], bsy[s], txo[s]};
            n_vec++;
            if (obs !== 3'b101) begin
                n_err++;
                $display("FAIL post_reset_idle[%0d]: got %b expected 101", s, obs);
            end
        end
    endtask

    task automatic test_8n1();
        send_frames(0, 1, 9'h076, 9'h000, "8n1_76");
        send_frames(0, 1, 9'($urandom_range(0, 255)), 9'h000, "8n1_rand");
    endtask

    task automatic test_parity();
        send_frames(1, 1, 9'h076, 9'h000, "even_76");
        send_frames(2, 1, 9'h076, 9'h000, "odd_76");
        send_frames(1, 1, 9'h0C3, 9'h000, "even_c3");
        send_frames(2, 1, 9'h001, 9'h000, "odd_01");
    endtask

    task automatic test_7n2();
        send_frames(3, 1, 9'h055, 9'h000, "7n2_55");
        send_frames(3, 1, 9'h07F, 9'h000, "7n2_7f");
    endtask

    task automatic test_back_to_back();
        send_frames(0, 2, 9'h0A5, 9'h03C, "b2b_a5_3c");
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] obs;
        logic [2:0] exp;
        @(negedge clk);
        valid[0] = 1'b1;
        data = 9'h076;
        push_frame(0, 9'h076);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            valid[0] = 1'b0;
            obs = {ready[0], bsy[0], txo[0]};
            exp = exp_q.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL abort_pre clk %0d: got %b expected %b", i, obs, exp);
            end
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        obs = {ready[0], bsy[0], txo[0]};
        n_vec++;
        if (obs !== 3'b001) begin
            n_err++;
            $display("FAIL abort_in_reset: got %b expected 001", obs);
        end
        reset = 1'b0;
        @(negedge clk);
        obs = {ready[0], bsy[0], txo[0]};
        n_vec++;
        if (obs !== 3'b101) begin
            n_err++;
            $display("FAIL abort_after_reset: got %b expected 101", obs);
        end
        send_frames(0, 1, 9'h05A, 9'h000, "after_abort_5a");
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        logic [1:0] obs;
        logic [1:0] exp;
        int len;
        len = frame_clocks(0);
        @(negedge clk);
        brk[0] = 1'b1;
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            if (i == 2) brk[0] = 1'b0;
            obs = {ready[0], txo[0]};
            exp = (i < len) ? 2'b00 : 2'b11;
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL break clk %0d {ready,tx_out}: got %b expected %b", i, obs, exp);
            end
        end
        send_frames(0, 1, 9'h0E1, 9'h000, "after_break_e1");
    endtask
`endif

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter; next generation of the fixed 8N1 uart_tx.
- Adds configurable data width, parity and stop bits.
- Adds a valid/ready input handshake in place of a bare enable, and a busy flag.
- Sits between a byte producer (CPU/FIFO) and the board TX pin; one frame in flight at a time.

Parameters:
CLKS_PER_BIT, 16, clocks per serial bit; legal range 2..65535.
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
tx_valid  input  1  producer has a word on tx_data.
tx_ready  output  1  block can accept a word this cycle.
tx_data  input  DATA_BITS  payload word, LSB transmitted first.
tx_out  output  1  serial line; idle high.
busy  output  1  frame in progress; high from acceptance until the last stop bit completes.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: tx_out = 1, busy = 0, FSM = IDLE, bit and baud counters = 0. tx_ready is 1 from the first cycle after reset deasserts.
- While reset is high, tx_ready = 0.
- Reset mid-frame aborts the frame. tx_out returns high on the next edge; no partial stop bit is sent.
- Handshake:
  - A word is accepted on any edge where tx_valid && tx_ready.
  - tx_ready = (state == IDLE) && !reset.
  - tx_data is captured into a shift register on acceptance; the producer may change it afterwards.
  - tx_valid without tx_ready is held off, not dropped; the block must not sample tx_data.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - PARITY state is skipped when PARITY = 0.
  - Every state except IDLE lasts exactly CLKS_PER_BIT clocks, counted by a baud counter that runs 0..CLKS_PER_BIT-1.
  - START drives 0.
  - DATA shifts DATA_BITS bits, LSB first.
  - PARITY drives the XOR of the payload (even), or its inverse (odd).
  - STOP drives 1 for STOP_BITS*CLKS_PER_BIT clocks.
- tx_out is registered. The first START cycle appears on tx_out the cycle after acceptance.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT clocks.
- Back-to-back frames: after the final STOP clock the FSM spends at least one cycle in IDLE with tx_ready = 1. If tx_valid is held high, inter-frame idle-high gap = 1 clock.
- busy rises on the cycle after acceptance and falls on the cycle the FSM re-enters IDLE.
- Illegal parameter values stop elaboration via a generate-time check (e.g. an instantiated error module / $error in a generate if).

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input port tx_break (1 bit).
  - When tx_break is high in IDLE, the FSM enters BREAK: tx_out = 0 for as long as tx_break stays high, with a minimum of (frame length) clocks. tx_ready = 0 throughout BREAK.
  - tx_break is ignored mid-frame and sampled only in IDLE.
  - If tx_break and tx_valid are both high in IDLE, break wins and the word is not accepted.
- Undefined: no tx_break port and no BREAK state; behaviour is otherwise identical.

Decomposition:
- Package uart_pkg holds:
  - parity encoding constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2;
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the frame-length helper function.
- One sub-module, uart_baud_tick (parameter CLKS_PER_BIT; ports clk, reset, clear, tick):
  - free-running counter;
  - pulses tick on count CLKS_PER_BIT-1;
  - cleared on acceptance so every bit is exactly aligned.
- It is reusable by the future uart_rx.

Test Plan:
1. CLKS_PER_BIT=4, 8N1; after reset, hold tx_valid=1 with tx_data=8'h76 for one accepted cycle. Required: tx_out = 0,0,1,1,0,1,1,1,0,1, each bit 4 clocks, 40 clocks total; busy high for exactly 40 clocks.
2. Same configuration, PARITY=2, then PARITY=1, data 8'h76 (five ones). Required: parity bit = 1 (even) and 0 (odd); frame 44 clocks.
3. DATA_BITS=7, STOP_BITS=2, data 7'h55. Required: bits 1,0,1,0,1,0,1 LSB first; stop held high for 8 clocks; total 40 clocks.
4. tx_valid held high with 8'hA5 then 8'h3C queued. Required: exactly a 1-clock idle-high gap between frames; second word not sampled before tx_ready = 1; tx_data changed while busy has no effect.
5. Assert reset at clock 15 of a frame. Required: tx_out = 1 and busy = 0 on the next edge; tx_ready = 1 once reset drops; next frame transmits cleanly.
6. With UART_TX_BREAK_EN, tx_break pulsed for 3 clocks in IDLE. Required: tx_out low for the minimum 40 clocks, tx_ready = 0 throughout, then return to IDLE high.
